// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver with 16x oversampling. Recovers bytes from the idle-high
//   serial line and presents them as a held level on rx_data, which the
//   downstream LED command decoder samples directly.
//
//   Parameters
//     CLK_HZ      system clock frequency in Hz
//     BAUD        line baud rate
//     OVERSAMPLE  oversample ticks per bit (only 16 is supported)
//
//   Ports
//     clk        system clock, all logic on posedge
//     rst        synchronous reset, active-high
//     rx_in      raw asynchronous serial line, idle high
//     rx_data    last correctly framed byte, held between frames
//     rx_valid   one-cycle pulse when rx_data is updated
//     frame_err  one-cycle pulse when the stop bit is sampled low
//     rx_busy    high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int div_round(input int num, input int den);
        return (num + den / 2) / den;
    endfunction

    localparam int DIV   = div_round(CLK_HZ, BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               rx_meta_p0;
    logic               rx_s;
    logic               rx_prev;
    logic               fall;

    logic [DIV_W-1:0]   tick_cnt;
    logic               os_tick;
    logic [3:0]         sample_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift_reg;

    logic               clr_cnt;
    logic               clr_sample;
    logic               shift_en;
    logic               load_data;
    logic               set_ferr;

    // ---- stage: input synchronizer and edge detect ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
        end else begin
            rx_meta_p0 <= rx_in;
            rx_s       <= rx_meta_p0;
            rx_prev    <= rx_s;
        end
    end

    // Only a genuine high-to-low transition starts a frame; a line that is
    // already low (break, stuck line, or a failed stop bit) is ignored.
    assign fall = rx_prev & ~rx_s;

    // ---- stage: oversample tick, sample and bit counters ----
    assign os_tick = (tick_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            tick_cnt   <= '0;
            sample_cnt <= '0;
            bit_cnt    <= '0;
        end else begin
            tick_cnt <= os_tick ? '0 : tick_cnt + 1'b1;
            if (clr_sample) begin
                sample_cnt <= '0;
            end else if (os_tick) begin
                sample_cnt <= sample_cnt + 4'd1;
            end
            if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // ---- stage: frame FSM next-state ----
    always_comb begin
        state_nxt  = state;
        clr_cnt    = 1'b0;
        clr_sample = 1'b0;
        shift_en   = 1'b0;
        load_data  = 1'b0;
        set_ferr   = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                    clr_cnt   = 1'b1;
                end
            end
            START: begin
                // 8th tick lands mid start bit; a high line here was a glitch.
                if (os_tick && sample_cnt == 4'd7) begin
                    if (!rx_s) begin
                        state_nxt  = DATA;
                        clr_sample = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (os_tick && sample_cnt == 4'd15) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is caught.
                if (os_tick && sample_cnt == 4'd15) begin
                    state_nxt = IDLE;
                    if (rx_s) begin
                        load_data = 1'b1;
                    end else begin
                        set_ferr = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- stage: state and output registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rx_busy   <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_data   <= 8'h00;
        end else begin
            state     <= state_nxt;
            rx_busy   <= (state_nxt != IDLE);
            rx_valid  <= load_data;
            frame_err <= set_ferr;
            if (load_data) begin
                rx_data <= shift_reg;
            end
        end
    end

    // Data bits arrive LSB first, so shift in from the top.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int BIT_NOM  = 868;   // 100 MHz / 115200
    localparam int BIT_FAST = 851;   // 100 MHz / (115200 * 1.02)
    localparam int BIT_SLOW = 886;   // 100 MHz / (115200 * 0.98)
    localparam int OS_CLK   = 54;    // clocks per oversample tick

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(
        .CLK_HZ    (100_000_000),
        .BAUD      (115200),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed events, sampled on the falling edge.
    logic [7:0] got_q[$];
    int         ferr_cnt  = 0;
    longint     t_valid   = 0;
    longint     t_start   = 0;
    bit         both_seen = 1'b0;
    bit         wide_seen = 1'b0;
    logic       prev_v    = 1'b0;
    logic       prev_f    = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            got_q.push_back(rx_data);
            t_valid = cyc;
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (rx_valid === 1'b1 && frame_err === 1'b1) both_seen = 1'b1;
        if ((rx_valid === 1'b1 && prev_v === 1'b1) ||
            (frame_err === 1'b1 && prev_f === 1'b1)) wide_seen = 1'b1;
        prev_v = rx_valid;
        prev_f = frame_err;
    end

    // Reference model: what a receiver must report for each line frame.
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    logic [7:0] exp_last = 8'h00;

    function automatic void model_frame(input logic [7:0] b, input bit stop);
        bit line[10];
        int val;
        line[0] = 1'b0;
        for (int i = 0; i < 8; i++) line[i+1] = b[i];
        line[9] = stop;
        val = 0;
        for (int i = 0; i < 8; i++) val += int'(line[i+1]) * (1 << i);
        if (line[9]) begin
            exp_q.push_back(8'(val));
            exp_last = 8'(val);
        end else begin
            exp_ferr++;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Drives one frame; caller is aligned to a falling clock edge.
    task automatic send_byte(input logic [7:0] b, input int bclk, input bit stop, input bit track);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        if (track) model_frame(b, stop);
        t_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_in = fr[i];
            repeat (bclk) @(negedge clk);
        end
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_ferr"}, 32'(ferr_cnt), 32'(exp_ferr));
        check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_last));
        got_q.delete();
        exp_q.delete();
        ferr_cnt = 0;
        exp_ferr = 0;
    endtask

    initial begin
        logic [7:0] b;
        longint     lat;
        logic [7:0] rst_byte;

        // Reset state
        repeat (5) @(negedge clk);
        check("reset_rx_data",   32'(rx_data),   32'h00);
        check("reset_rx_valid",  32'(rx_valid),  32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_rx_busy",   32'(rx_busy),   32'h0);
        rst = 1'b0;
        repeat (100) @(negedge clk);

        // Single byte 0x81 and its latency from the start edge
        send_byte(8'h81, BIT_NOM, 1'b1, 1'b1);
        repeat (50) @(negedge clk);
        lat = t_valid - t_start;
        check("t1_latency_window", 32'(lat >= 8141 && lat <= 8357), 32'h1);
        check_frames("t1");

        // Random bytes with random idle gaps
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            send_byte(b, BIT_NOM, 1'b1, 1'b1);
            repeat ($urandom_range(0, 300)) @(negedge clk);
        end
        repeat (50) @(negedge clk);
        check_frames("rand");

        // Glitch shorter than half a bit
        rx_in = 1'b0;
        repeat (100) @(negedge clk);
        check("glitch_busy_high", 32'(rx_busy), 32'h1);
        repeat (3 * OS_CLK - 100) @(negedge clk);
        rx_in = 1'b1;
        repeat (8 * OS_CLK + 20 - 3 * OS_CLK) @(negedge clk);
        check("glitch_busy_low", 32'(rx_busy), 32'h0);
        repeat (2000) @(negedge clk);
        check_frames("glitch");

        // Good byte followed by a frame with a low stop bit
        send_byte(8'h81, BIT_NOM, 1'b1, 1'b1);
        send_byte(8'h55, BIT_NOM, 1'b0, 1'b1);
        rx_in = 1'b1;
        repeat (200) @(negedge clk);
        check_frames("ferr");

        // Back-to-back frames, zero idle gap
        for (int k = 0; k < 6; k++) send_byte(8'h80 + 8'(k), BIT_NOM, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom), BIT_NOM, 1'b1, 1'b1);
        repeat (200) @(negedge clk);
        check_frames("b2b");

        // Reset in the middle of data bit 4; upper nibble high keeps the
        // remainder of the abandoned frame free of falling edges.
        rst_byte = {4'hF, 4'($urandom)};
        fork
            send_byte(rst_byte, BIT_NOM, 1'b1, 1'b0);
            begin
                repeat (BIT_NOM * 5 + BIT_NOM / 2) @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                check("midrst_rx_data",   32'(rx_data),   32'h00);
                check("midrst_rx_valid",  32'(rx_valid),  32'h0);
                check("midrst_frame_err", 32'(frame_err), 32'h0);
                check("midrst_rx_busy",   32'(rx_busy),   32'h0);
            end
        join
        exp_last = 8'h00;
        repeat (300) @(negedge clk);
        got_q.delete();
        ferr_cnt = 0;
        send_byte(8'h83, BIT_NOM, 1'b1, 1'b1);
        repeat (100) @(negedge clk);
        check_frames("after_rst");

        // Transmitter baud error of +2% and -2%
        send_byte(8'hA5, BIT_FAST, 1'b1, 1'b1);
        repeat (100) @(negedge clk);
        check_frames("fast_a5");
        send_byte(8'hA5, BIT_SLOW, 1'b1, 1'b1);
        repeat (100) @(negedge clk);
        check_frames("slow_a5");
        for (int k = 0; k < 2; k++) begin
            send_byte(8'($urandom), BIT_FAST, 1'b1, 1'b1);
            send_byte(8'($urandom), BIT_SLOW, 1'b1, 1'b1);
        end
        repeat (100) @(negedge clk);
        check_frames("tol_rand");

        // Pulse shape over the whole run
        check("never_both_high", 32'(both_seen), 32'h0);
        check("pulses_one_cycle", 32'(wide_seen), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
